// File: rtl/cdc_dst_fsm.sv
// -----------------------------------------------------------------------------
// cdc_dst_fsm
//
// Receiving half of a two-phase (toggle) request/acknowledge clock-domain
// crossing. Each toggle of async_req_i announces a new word on async_data_i.
// The word is presented locally on a valid/ready interface. Once the local
// consumer accepts it, async_ack_o is toggled back to the source.
//
// Ports:
//   clk_i        destination-domain clock
//   rst_ni       asynchronous active-low reset
//   async_req_i  two-phase request from the source domain
//   async_data_i source word, held stable while a request is outstanding
//   async_ack_o  two-phase acknowledge to the source domain (registered)
//   data_o       received word
//   valid_o      data_o holds an unconsumed word
//   ready_i      local consumer accepts data_o
// -----------------------------------------------------------------------------
module cdc_dst_fsm #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  async_req_i,
  input  logic [DATA_WIDTH-1:0] async_data_i,
  output logic                  async_ack_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  typedef enum logic {
    WAIT_REQ   = 1'b0,
    WAIT_GRANT = 1'b1
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_sync;
  logic                   pending;

  // Plain flop chain; this is the only logic that sees async_req_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_req_i};
    end
  end

  assign req_sync = sync_q[SYNC_STAGES-1];

  // Level compare rather than an edge pulse: a request stays pending until
  // it is acknowledged, however long the consumer stalls.
  assign pending = (req_sync != async_ack_o);

  // async_data_i is captured without synchronization: by the time the
  // request has crossed the chain the source has held it for SYNC_STAGES
  // cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= WAIT_REQ;
      async_ack_o <= 1'b0;
      valid_o     <= 1'b0;
      data_o      <= '0;
    end else begin
      case (state_q)
        WAIT_REQ: begin
          if (pending) begin
            data_o  <= async_data_i;
            valid_o <= 1'b1;
            state_q <= WAIT_GRANT;
          end
        end
        WAIT_GRANT: begin
          if (valid_o && ready_i) begin
            valid_o     <= 1'b0;
            async_ack_o <= ~async_ack_o;
            state_q     <= WAIT_REQ;
          end
        end
        default: begin
          state_q <= WAIT_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_dst_fsm.sv
`timescale 1ns/10ps
module tb_cdc_dst_fsm;

  logic        clk;
  logic        clk_s;
  logic        rst_n;
  logic        async_req;
  logic [31:0] async_data;
  logic        ack;
  logic [31:0] data_o;
  logic        valid;
  logic        ready;

  logic        req4;
  logic [31:0] data4;
  logic        ack4;
  logic [31:0] dout4;
  logic        valid4;
  logic        ready4;

  real         src_half = 5.0;
  logic        ack_s1;
  logic        ack_s2;

  int          checks = 0;
  int          passes = 0;

  cdc_dst_fsm #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .async_req_i  (async_req),
    .async_data_i (async_data),
    .async_ack_o  (ack),
    .data_o       (data_o),
    .valid_o      (valid),
    .ready_i      (ready)
  );

  cdc_dst_fsm #(.DATA_WIDTH(32), .SYNC_STAGES(4)) dut4 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .async_req_i  (req4),
    .async_data_i (data4),
    .async_ack_o  (ack4),
    .data_o       (dout4),
    .valid_o      (valid4),
    .ready_i      (ready4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    clk_s = 1'b0;
    forever #(src_half) clk_s = ~clk_s;
  end

  // Source-side ack synchronizer of the bench's source model.
  always @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      ack_s1 <= ack;
      ack_s2 <= ack_s1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        req;
    logic [31:0] data;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_ack;
  } vec_t;

  vec_t vecs[12];

  logic [31:0] exp_q[$];
  logic [31:0] rx_q[$];
  bit          src_done;

  task automatic send(input logic [31:0] w, input bit jitter);
    int g;
    @(posedge clk_s);
    if (jitter) #($urandom_range(0, 30) * 0.1);
    async_data = w;
    async_req  = ~async_req;
    g = 0;
    while (ack_s2 !== async_req && g < 2000) begin
      @(posedge clk_s);
      g++;
    end
    if (g >= 2000) check("src_ack_wait", 32'(g < 2000), 32'd1);
  endtask

  task automatic run_stream(input int n, input bit rnd, input real half, input bit jitter);
    int toggles;
    int drops;
    int guard;
    logic pv, pr, prev_ack, r;
    src_half = half;
    exp_q.delete();
    rx_q.delete();
    src_done = 1'b0;
    toggles  = 0;
    drops    = 0;
    guard    = 0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          logic [31:0] w;
          w = rnd ? $urandom : 32'(i);
          exp_q.push_back(w);
          send(w, jitter);
        end
        src_done = 1'b1;
      end
      begin
        pv       = valid;
        pr       = ready;
        prev_ack = ack;
        while (!(src_done && rx_q.size() == n) && guard < 60000) begin
          @(negedge clk);
          guard++;
          if (pv && !pr && !valid) drops++;
          if (ack !== prev_ack) toggles++;
          prev_ack = ack;
          r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          ready = r;
          if (valid && r) rx_q.push_back(data_o);
          pv = valid;
          pr = r;
        end
        ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (ack !== prev_ack) toggles++;
          prev_ack = ack;
        end
        check("stream_guard", 32'(guard < 60000), 32'd1);
      end
    join
    check("stream_count", rx_q.size(), n);
    check("stream_ack_toggles", toggles, n);
    check("stream_valid_drop", drops, 0);
    for (int i = 0; i < n; i++) begin
      if (i < rx_q.size()) check("stream_word", rx_q[i], exp_q[i]);
    end
  endtask

  initial begin
    int lat;
    vecs[0]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1};
    vecs[5]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1};
    vecs[6]  = '{1'b0, 32'h12345678, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1};
    vecs[7]  = '{1'b0, 32'h12345678, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1};
    vecs[8]  = '{1'b0, 32'h12345678, 1'b0, 1'b1, 32'h12345678, 1'b1};
    vecs[9]  = '{1'b0, 32'h12345678, 1'b0, 1'b1, 32'h12345678, 1'b1};
    vecs[10] = '{1'b0, 32'h12345678, 1'b1, 1'b0, 32'h12345678, 1'b0};
    vecs[11] = '{1'b0, 32'h12345678, 1'b1, 1'b0, 32'h12345678, 1'b0};

    rst_n      = 1'b0;
    async_req  = 1'b0;
    async_data = '0;
    ready      = 1'b0;
    req4       = 1'b0;
    data4      = '0;
    ready4     = 1'b1;
    repeat (3) tick();
    check("rst_valid", valid, 0);
    check("rst_ack", ack, 0);
    check("rst_data", data_o, 0);
    check("rst_valid4", valid4, 0);
    rst_n = 1'b1;

    // Single transfer with ready early, then a second with a short stall.
    for (int i = 0; i < 12; i++) begin
      async_req  = vecs[i].req;
      async_data = vecs[i].data;
      ready      = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_data", i), data_o, vecs[i].exp_data);
      check($sformatf("vec%0d_ack", i), ack, vecs[i].exp_ack);
    end

    // Backpressure for 10 cycles after valid rises.
    async_req  = 1'b1;
    async_data = 32'hA5A5A5A5;
    ready      = 1'b0;
    tick(); check("bp_lat1", valid, 0);
    tick(); check("bp_lat2", valid, 0);
    tick(); check("bp_lat3", valid, 1);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_hold_valid", valid, 1);
      check("bp_hold_data", data_o, 32'hA5A5A5A5);
      check("bp_hold_ack", ack, 0);
    end
    ready = 1'b1;
    tick();
    check("bp_release_valid", valid, 0);
    check("bp_release_ack", ack, 1);

    // Reset while a word waits for grant.
    async_req  = 1'b0;
    async_data = 32'h0BADF00D;
    ready      = 1'b0;
    repeat (3) tick();
    check("mid_valid_before", valid, 1);
    rst_n     = 1'b0;
    async_req = 1'b0;
    #2;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_data", data_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("post_rst_idle", valid, 0);
    end
    async_req  = 1'b1;
    async_data = 32'hCAFEF00D;
    ready      = 1'b1;
    repeat (3) tick();
    check("post_rst_valid", valid, 1);
    check("post_rst_data", data_o, 32'hCAFEF00D);
    tick();
    check("post_rst_ack", ack, 1);
    check("post_rst_drop", valid, 0);

    // Four-stage synchronizer latency.
    req4  = 1'b1;
    data4 = 32'h5A5A0004;
    lat   = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (valid4) begin
        lat = c;
        break;
      end
    end
    check("sync4_latency", lat, 5);
    check("sync4_data", dout4, 32'h5A5A0004);
    tick();
    check("sync4_ack", ack4, 1);

    // Streams against a source model: slow source, fast source, random.
    ready = 1'b0;
    run_stream(100, 1'b0, 15.0, 1'b0);
    run_stream(100, 1'b0, 1.7, 1'b0);
    run_stream(1000, 1'b1, 3.7, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
